// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard.
//  - kind_e: producer class of the instruction in decode
//  - CNT_W:  width of each per-register countdown
//  - clamp_lat / clamp_flush: keep latency and flush-length parameters inside
//    the range the counters can represent
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,  // single-cycle ALU op or no destination: always forwardable
    KIND_LOAD = 2'b01,
    KIND_IN   = 2'b10,
    KIND_MUL  = 2'b11
  } kind_e;

  localparam int CNT_W   = 3;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = (1 << CNT_W) - 1;

  localparam int FLUSH_MIN = 1;
  localparam int FLUSH_MAX = 3;

  // A latency of 0 would make the producer indistinguishable from KIND_NONE,
  // and anything above LAT_MAX would wrap the countdown, so both are clamped.
  function automatic logic [CNT_W-1:0] clamp_lat(input int lat);
    if (lat < LAT_MIN) begin
      return CNT_W'(LAT_MIN);
    end else if (lat > LAT_MAX) begin
      return CNT_W'(LAT_MAX);
    end else begin
      return CNT_W'(lat);
    end
  endfunction

  function automatic logic [1:0] clamp_flush(input int n);
    if (n < FLUSH_MIN) begin
      return 2'(FLUSH_MIN);
    end else if (n > FLUSH_MAX) begin
      return 2'(FLUSH_MAX);
    end else begin
      return 2'(n);
    end
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: a small countdown that says how many more cycles the
// register's pending result is not yet forwardable.
// Ports:
//  clk, rst   clock / asynchronous active-high reset
//  load       reload the countdown with load_val (wins over decrement)
//  load_val   new countdown value
//  busy       countdown is nonzero
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode/execute hazard scoreboard.
// Tracks, per register, how long a not-yet-forwardable result is outstanding
// and stalls decode while the decoded instruction reads such a register.
// A taken branch squashes IR and p3 for BR_FLUSH cycles; branch beats stall.
// Ports:
//  clk, rst                 clock / asynchronous active-high reset
//  id_valid                 decode holds a valid instruction
//  id_rs, id_rt, *_used     source addresses and whether they are read
//  id_rd, id_kind           destination and producer class (kind_e)
//  branch_taken             taken branch resolved this cycle
//  pc_wren, ir_wren         fetch/decode advance enables
//  ir_flush, p3_flush       squash decode / execute stage registers
//  busy_vec                 per-register pending flags
//  stall_cnt, flush_cnt     saturating performance counters
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int LD_LAT     = 1,
  parameter int IN_LAT     = 1,
  parameter int MUL_LAT    = 3,
  parameter int BR_FLUSH   = 1,
  parameter int R0_ZERO    = 0,
  parameter int PERF_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         id_rs,
  input  logic [REG_ADDR_W-1:0]         id_rt,
  input  logic                          id_rs_used,
  input  logic                          id_rt_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic [1:0]                    id_kind,
  input  logic                          branch_taken,
  output logic                          pc_wren,
  output logic                          ir_wren,
  output logic                          ir_flush,
  output logic                          p3_flush,
  output logic [(1<<REG_ADDR_W)-1:0]    busy_vec,
  output logic [PERF_W-1:0]             stall_cnt,
  output logic [PERF_W-1:0]             flush_cnt
);

  localparam int NREGS = 1 << REG_ADDR_W;

  localparam logic [CNT_W-1:0] LD_LAT_C  = clamp_lat(LD_LAT);
  localparam logic [CNT_W-1:0] IN_LAT_C  = clamp_lat(IN_LAT);
  localparam logic [CNT_W-1:0] MUL_LAT_C = clamp_lat(MUL_LAT);
  // The branch cycle itself is the first flush cycle, so the counter only
  // has to cover the remaining ones.
  localparam logic [1:0] FLUSH_RELOAD = clamp_flush(BR_FLUSH) - 2'd1;
  localparam logic       R0_HARD      = (R0_ZERO != 0);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] load_vec;
  logic [CNT_W-1:0] load_val;

  logic hazard;
  logic flushing;
  logic issue;
  logic produces;

  logic [1:0]        flush_q;
  logic [1:0]        flush_d;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q;
  logic [PERF_W-1:0] flush_cnt_d;

  // ---------------------------------------------------------------- hazard
  assign hazard   = id_valid & ((id_rs_used & busy[id_rs]) | (id_rt_used & busy[id_rt]));
  assign flushing = (flush_q != 2'd0) | branch_taken;
  assign issue    = id_valid & ~hazard & ~flushing;

  // A hardwired r0 can never hold a pending result, so it is never loaded.
  assign produces = issue & (id_kind != KIND_NONE) & ~(R0_HARD & (id_rd == '0));

  always_comb begin
    load_val = '0;
    case (kind_e'(id_kind))
      KIND_LOAD: load_val = LD_LAT_C;
      KIND_IN:   load_val = IN_LAT_C;
      KIND_MUL:  load_val = MUL_LAT_C;
      default:   load_val = '0;
    endcase
  end

  // ------------------------------------------------------------ scoreboard
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
      assign load_vec[gi] = produces & (id_rd == REG_ADDR_W'(gi));

      sb_entry u_entry (
        .clk      (clk),
        .rst      (rst),
        .load     (load_vec[gi]),
        .load_val (load_val),
        .busy     (busy[gi])
      );
    end
  endgenerate

  assign busy_vec = busy;

  // --------------------------------------------------------------- outputs
  // Branch wins over stall: the stalled instruction is on the wrong path
  // anyway, so it is squashed instead of held.
  always_comb begin
    pc_wren  = 1'b1;
    ir_wren  = 1'b1;
    ir_flush = 1'b0;
    p3_flush = 1'b0;
    if (flushing) begin
      ir_flush = 1'b1;
      p3_flush = 1'b1;
    end else if (hazard) begin
      pc_wren  = 1'b0;
      ir_wren  = 1'b0;
      p3_flush = 1'b1;
    end
  end

  // ---------------------------------------------------------- flush counter
  always_comb begin
    flush_d = flush_q;
    if (branch_taken) begin
      flush_d = FLUSH_RELOAD;
    end else if (flush_q != 2'd0) begin
      flush_d = flush_q - 2'd1;
    end
  end

  // ---------------------------------------------------------- perf counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard & ~flushing & (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ir_flush & (flush_cnt_q != {PERF_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q     <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Two instances share the stimulus:
//  dut_a: default parameters (BR_FLUSH=1, R0_ZERO=0, PERF_W=16)
//  dut_b: BR_FLUSH=2, R0_ZERO=1, PERF_W=4 (narrow counters reach saturation quickly)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or just after the rising edge.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used;
  logic [1:0] id_kind;
  logic       branch_taken;

  logic        a_pc, a_ir, a_irf, a_p3;
  logic [7:0]  a_busy;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_ir, b_irf, b_p3;
  logic [7:0]  b_busy;
  logic [3:0]  b_stall, b_flush;

  logic [3:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc, a_ir, a_irf, a_p3};
  assign b_ctl = {b_pc, b_ir, b_irf, b_p3};

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_kind(id_kind),
    .branch_taken(branch_taken), .pc_wren(a_pc), .ir_wren(a_ir), .ir_flush(a_irf),
    .p3_flush(a_p3), .busy_vec(a_busy), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  hazard_scoreboard #(.BR_FLUSH(2), .R0_ZERO(1), .PERF_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_kind(id_kind),
    .branch_taken(branch_taken), .pc_wren(b_pc), .ir_wren(b_ir), .ir_flush(b_irf),
    .p3_flush(b_p3), .busy_vec(b_busy), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                       input logic [1:0] kind, input logic br);
    id_valid     = v;
    id_rs        = rs;
    id_rs_used   = rsu;
    id_rt        = rt;
    id_rt_used   = rtu;
    id_rd        = rd;
    id_kind      = kind;
    branch_taken = br;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, KIND_NONE, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- 1: reset
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mid();
    check("t1 a ctl", a_ctl, 4'b1100);
    check("t1 b ctl", b_ctl, 4'b1100);
    check("t1 a busy", a_busy, 8'h00);
    check("t1 a stall", a_stall, 0);
    check("t1 a flush", a_flush, 0);
    tick();

    // ---------------- 2: LD r2 then ADD using r2 -> one stall
    drive(1, 3'd0, 0, 3'd0, 0, 3'd2, KIND_LOAD, 0);
    mid();
    check("t2 ld issue a ctl", a_ctl, 4'b1100);
    tick();
    drive(1, 3'd2, 1, 3'd0, 0, 3'd4, KIND_NONE, 0);
    mid();
    check("t2 stall a ctl", a_ctl, 4'b0001);
    check("t2 stall b ctl", b_ctl, 4'b0001);
    check("t2 stall a busy", a_busy, 8'h04);
    tick();
    mid();
    check("t2 release a ctl", a_ctl, 4'b1100);
    check("t2 release a busy", a_busy, 8'h00);
    check("t2 a stall_cnt", a_stall, 1);
    tick();

    // ---------------- 3: MUL r3 then dependent on rt=3 -> three stalls
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, KIND_MUL, 0);
    mid();
    check("t3 mul issue a busy", a_busy, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd0, 0, 3'd3, 1, 3'd5, KIND_NONE, 0);
      mid();
      check($sformatf("t3 stall%0d a ctl", i), a_ctl, 4'b0001);
      check($sformatf("t3 stall%0d a busy", i), a_busy, 8'h08);
      tick();
    end
    mid();
    check("t3 release a ctl", a_ctl, 4'b1100);
    check("t3 a stall_cnt", a_stall, 4);
    check("t3 b stall_cnt", b_stall, 4);
    tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, KIND_MUL, 0);
    mid();
    tick();
    drive(1, 3'd0, 0, 3'd3, 0, 3'd5, KIND_NONE, 0);
    mid();
    check("t3 rt unused a ctl", a_ctl, 4'b1100);
    check("t3 rt unused a busy", a_busy, 8'h08);
    tick();
    idle();
    tick();
    tick();
    mid();
    check("t3 drained a busy", a_busy, 8'h00);
    tick();

    // ---------------- 4: stall on r2 plus branch in same cycle
    drive(1, 3'd0, 0, 3'd0, 0, 3'd2, KIND_LOAD, 0);
    mid();
    tick();
    drive(1, 3'd2, 1, 3'd0, 0, 3'd4, KIND_NONE, 1);
    mid();
    check("t4 branch a ctl", a_ctl, 4'b1111);
    check("t4 branch b ctl", b_ctl, 4'b1111);
    check("t4 branch a busy", a_busy, 8'h04);
    tick();
    idle();
    mid();
    check("t4 flush2 a ctl", a_ctl, 4'b1100);
    check("t4 flush2 b ctl", b_ctl, 4'b1111);
    check("t4 a busy cleared", a_busy, 8'h00);
    check("t4 b busy cleared", b_busy, 8'h00);
    tick();
    mid();
    check("t4 after b ctl", b_ctl, 4'b1100);
    check("t4 a flush_cnt", a_flush, 1);
    check("t4 b flush_cnt", b_flush, 2);
    check("t4 a stall_cnt unchanged", a_stall, 4);
    tick();

    // ---------------- 5: LD r0 then use r0
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, KIND_LOAD, 0);
    mid();
    tick();
    drive(1, 3'd0, 1, 3'd0, 0, 3'd4, KIND_NONE, 0);
    mid();
    check("t5 r0 a ctl", a_ctl, 4'b0001);
    check("t5 r0 b ctl", b_ctl, 4'b1100);
    check("t5 r0 a busy", a_busy, 8'h01);
    check("t5 r0 b busy", b_busy, 8'h00);
    tick();
    idle();
    mid();
    check("t5 a stall_cnt", a_stall, 5);
    check("t5 b stall_cnt", b_stall, 4);
    tick();

    // ---------------- 6: reset pulse mid MUL stall
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, KIND_MUL, 0);
    mid();
    tick();
    drive(1, 3'd0, 0, 3'd3, 1, 3'd5, KIND_NONE, 0);
    mid();
    check("t6 stall a ctl", a_ctl, 4'b0001);
    tick();
    rst = 1'b1;
    #1;
    check("t6 rst a busy", a_busy, 8'h00);
    check("t6 rst a ctl", a_ctl, 4'b1100);
    check("t6 rst b ctl", b_ctl, 4'b1100);
    check("t6 rst a stall_cnt", a_stall, 0);
    check("t6 rst a flush_cnt", a_flush, 0);
    rst = 1'b0;
    mid();
    check("t6 post rst a ctl", a_ctl, 4'b1100);
    tick();

    // ---------------- 6b: stall counter saturation (dut_b 4-bit)
    for (int r = 0; r < 6; r++) begin
      drive(1, 3'd0, 0, 3'd0, 0, 3'd3, KIND_MUL, 0);
      mid();
      tick();
      for (int s = 0; s < 3; s++) begin
        drive(1, 3'd3, 1, 3'd0, 0, 3'd5, KIND_NONE, 0);
        mid();
        tick();
      end
      if (r == 4) begin
        check("t6 sat b stall 15", b_stall, 4'hF);
        check("t6 sat a stall 15", a_stall, 15);
      end
    end
    check("t6 sat b stall holds", b_stall, 4'hF);
    check("t6 sat a stall 18", a_stall, 18);

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
